bcd_conv_sched: RTL and testbench
=================================

Name: bcd_conv_sched

Overview:
- Round-robin scheduler that shares one binary-to-BCD/ASCII converter among N field formatters in the FIX message builder.
- Accepts 32-bit binary conversion requests, sequences the converter start/done handshake and returns ASCII text and digit width tagged with the requester id.
- One conversion in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must satisfy 2**ID_W >= N_REQ.
- TIMEOUT, 64, maximum WAIT cycles before abort. Used only with the optional feature.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ce_i  in  1  clock enable; when 0, all state and outputs hold.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester accept; one-hot or zero.
- req_data_i  in  N_REQ*32  packed binary operands; requester k occupies bits [32k+31:32k].
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  ID_W  id of the requester that owns the response.
- rsp_ascii_o  out  80  ASCII result.
- rsp_width_o  out  4  digit count.
- rsp_err_o  out  1  timeout error; tied 0 without the optional feature.
- conv_start_o  out  1  converter start, one-cycle pulse.
- conv_dat_o  out  32  converter operand.
- conv_rst_o  out  1  converter reset.
- conv_done_i  in  1  converter done pulse; results are valid in the same cycle.
- conv_ascii_i  in  80  converter ASCII result.
- conv_width_i  in  4  converter digit width.

Behaviour:
- Reset: state=IDLE, rr pointer=N_REQ-1 (so requester 0 wins first), all outputs 0 except conv_rst_o=1 while rst_i=1. Reset at any point, including mid-WAIT, returns to IDLE and drops any response.
- FSM states: IDLE, START, WAIT, RESP. Transitions occur only when ce_i=1.
- IDLE: the winner is the first requester with valid set, searching from rr pointer+1 with wrap-around. req_ready_o[winner] is asserted combinationally in that cycle. On the accepting edge, latch data and id, then go to START. With no request pending, stay in IDLE.
- START: conv_start_o=1 for exactly one cycle with conv_dat_o = latched data; go to WAIT. conv_dat_o holds its value until the next accept.
- WAIT: on conv_done_i, capture ascii and width, then go to RESP. conv_done_i is ignored in every state other than WAIT.
- RESP: rsp_valid_o=1 and all rsp_* outputs stable until rsp_ready_i=1. On the handshake: rr pointer = served id, go to IDLE.
- req_ready_o is always 0 outside IDLE. Changes on req_valid_i outside IDLE have no effect.
- Latency: accept at cycle 0, conv_start_o at cycle 1, converter done at 1+L, rsp_valid_o at 2+L. The next accept happens no earlier than the cycle after the response handshake.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0.

Optional Feature:
- Macro BCD_CONV_SCHED_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to WAIT and counts WAIT cycles with ce_i=1. If it reaches TIMEOUT with no done:
  - conv_rst_o pulses for one cycle;
  - go to RESP with rsp_err_o=1, rsp_ascii_o=0, rsp_width_o=0.
- If done and timeout occur in the same cycle, done wins with err=0.
- Undefined: no counter; WAIT can last indefinitely; rsp_err_o is tied 0.

Decomposition:
- Package bcd_conv_sched_pkg holds:
  - the state enum (IDLE/START/WAIT/RESP);
  - constants BIN_W=32, ASCII_W=80, DIGW_W=4;
  - the response struct (id, ascii, width, err).
- Sub-module rr_arbiter: combinational round-robin pick from a request vector and pointer; outputs a one-hot grant and an encoded id.

Test Plan (bench converter model returns ASCII "1234" right-justified and width 4, after L=10 cycles):
- Single request: req0 data=32'd1234 -> req_ready_o=4'b0001 at accept; conv_start_o pulse 1 cycle later with conv_dat_o=1234; rsp_valid_o at cycle 12 with id=0, width=4.
- All four requesters valid continuously -> served ids 0,1,2,3,0, with no id served twice before all others are served.
- rsp_ready_i held 0 for 5 cycles -> rsp_* outputs stable; req_ready_o stays 0; accept resumes the cycle after the handshake.
- ce_i=0 for 3 cycles during WAIT -> no state change; response delayed by exactly 3 cycles.
- rst_i asserted mid-WAIT -> next cycle in IDLE, all outputs 0, conv_rst_o=1 during reset, late conv_done_i ignored.
- With BCD_CONV_SCHED_TIMEOUT_EN, TIMEOUT=64 and the model never raising done -> conv_rst_o pulse and rsp_valid_o with rsp_err_o=1, ascii=0, width=0.

Source files
------------

// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the binary-to-BCD/ASCII converter scheduler.
package bcd_conv_sched_pkg;

  localparam int BIN_W    = 32;
  localparam int ASCII_W  = 80;
  localparam int DIGW_W   = 4;
  // Wide enough for any supported requester count (up to 8)
  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [ASCII_W-1:0]  ascii;
    logic [DIGW_W-1:0]   width;
    logic                err;
  } rsp_t;

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping around.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_id,
  output logic             any
);

  int               idx;
  logic [N_REQ-1:0] shifted;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    shifted  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx     = (int'(ptr) + k) % N_REQ;
      shifted = req >> idx;
      if (!any && shifted[0]) begin
        any      = 1'b1;
        grant    = N_REQ'(1) << idx;
        grant_id = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD/ASCII converter among N_REQ formatters.
// Optional macro BCD_CONV_SCHED_TIMEOUT_EN adds a WAIT timeout that resets the converter.
module bcd_conv_sched
  import bcd_conv_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ce_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*BIN_W-1:0] req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [ASCII_W-1:0]     rsp_ascii_o,
  output logic [DIGW_W-1:0]      rsp_width_o,
  output logic                   rsp_err_o,
  output logic                   conv_start_o,
  output logic [BIN_W-1:0]       conv_dat_o,
  output logic                   conv_rst_o,
  input  logic                   conv_done_i,
  input  logic [ASCII_W-1:0]     conv_ascii_i,
  input  logic [DIGW_W-1:0]      conv_width_i
);

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    grant;
  logic [ID_MAX_W-1:0] grant_id;
  logic [ID_MAX_W-1:0] ptr;
  logic                grant_any;
  logic [BIN_W-1:0]    lat_data;
  rsp_t                rsp_q;
  logic                timeout_hit;
  logic                conv_rst_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_MAX_W)
  ) u_arb (
    .req      (req_valid_i),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

`ifdef BCD_CONV_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counter restarts as WAIT is entered; the converter reset pulse follows an abort.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt   <= '0;
      conv_rst_q <= 1'b0;
    end else if (ce_i) begin
      conv_rst_q <= timeout_hit;
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign timeout_hit = (state == WAIT) && !conv_done_i && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = (TIMEOUT < 0);
  assign conv_rst_q  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ptr      <= ID_MAX_W'(N_REQ - 1);
      lat_data <= '0;
      rsp_q    <= '0;
    end else if (ce_i) begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        lat_data <= BIN_W'(req_data_i >> (int'(grant_id) * BIN_W));
        rsp_q.id <= grant_id;
      end
      // Done takes priority over a coincident timeout
      if (state == WAIT) begin
        if (conv_done_i) begin
          rsp_q.ascii <= conv_ascii_i;
          rsp_q.width <= conv_width_i;
          rsp_q.err   <= 1'b0;
        end else if (timeout_hit) begin
          rsp_q.ascii <= '0;
          rsp_q.width <= '0;
          rsp_q.err   <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready_i) begin
        ptr <= rsp_q.id;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = '0;
    conv_start_o = 1'b0;
    rsp_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = (ce_i && !rst_i) ? grant : '0;
        if (grant_any) state_nxt = START;
      end
      START: begin
        conv_start_o = !rst_i;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (conv_done_i || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = !rst_i;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_id_o    = ID_W'(rsp_q.id);
  assign rsp_ascii_o = rsp_q.ascii;
  assign rsp_width_o = rsp_q.width;
  assign rsp_err_o   = rsp_q.err;
  assign conv_dat_o  = lat_data;
  assign conv_rst_o  = rst_i | conv_rst_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: randomized requests against a decimal/round-robin model.
// Define BCD_CONV_SCHED_TIMEOUT_EN to also exercise the converter-timeout path.
`timescale 1ns/1ps
module tb_bcd_conv_sched;

  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int CONV_LAT = 10;
  localparam int MAX_WAIT = 200;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               ce_i;
  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [N_REQ*32-1:0] req_data_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [ID_W-1:0]    rsp_id_o;
  logic [79:0]        rsp_ascii_o;
  logic [3:0]         rsp_width_o;
  logic               rsp_err_o;
  logic               conv_start_o;
  logic [31:0]        conv_dat_o;
  logic               conv_rst_o;
  logic               conv_done_i;
  logic [79:0]        conv_ascii_i;
  logic [3:0]         conv_width_i;

  logic               model_done;
  logic               extra_done;
  logic               model_mute;
  logic               mdl_ce, mdl_start, mdl_rst, mdl_armed;
  logic [31:0]        mdl_dat;
  logic [79:0]        mdl_ascii;
  logic [3:0]         mdl_width;
  int                 mdl_remaining;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ref_ptr;

  assign conv_done_i = model_done | extra_done;

  bcd_conv_sched #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ce_i         (ce_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_ascii_o  (rsp_ascii_o),
    .rsp_width_o  (rsp_width_o),
    .rsp_err_o    (rsp_err_o),
    .conv_start_o (conv_start_o),
    .conv_dat_o   (conv_dat_o),
    .conv_rst_o   (conv_rst_o),
    .conv_done_i  (conv_done_i),
    .conv_ascii_i (conv_ascii_i),
    .conv_width_i (conv_width_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Decimal text of v, least significant digit in the lowest byte, no leading zeros.
  function automatic void decAscii(input logic [31:0] v, output logic [79:0] a, output logic [3:0] w);
    logic [31:0] t;
    t = v;
    a = '0;
    w = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || t != 0) begin
        a[i*8 +: 8] = 8'h30 + 8'(t % 10);
        w = w + 4'd1;
      end
      t = t / 10;
    end
  endfunction

  function automatic int pickRef(input logic [N_REQ-1:0] m, input int p);
    for (int k = 1; k <= N_REQ; k++) begin
      if (m[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  // Converter model: done arrives after CONV_LAT clock-enabled cycles and holds until consumed.
  initial begin
    model_done    = 1'b0;
    conv_ascii_i  = '0;
    conv_width_i  = '0;
    mdl_armed     = 1'b0;
    mdl_remaining = 0;
    forever begin
      @(negedge clk_i);
      mdl_ce    = ce_i;
      mdl_start = conv_start_o;
      mdl_rst   = conv_rst_o;
      mdl_dat   = conv_dat_o;
      @(posedge clk_i);
      #1;
      if (mdl_rst) begin
        mdl_armed  = 1'b0;
        model_done = 1'b0;
      end else if (mdl_ce) begin
        model_done = 1'b0;
        if (mdl_start) begin
          mdl_armed     = !model_mute;
          mdl_remaining = CONV_LAT - 1;
          decAscii(mdl_dat, mdl_ascii, mdl_width);
        end else if (mdl_armed) begin
          mdl_remaining = mdl_remaining - 1;
          if (mdl_remaining == 0) begin
            mdl_armed    = 1'b0;
            model_done   = 1'b1;
            conv_ascii_i = mdl_ascii;
            conv_width_i = mdl_width;
          end
        end
      end
    end
  end

  initial begin
    #(20000 * 10);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setData(input int k, input logic [31:0] v);
    req_data_i[k*32 +: 32] = v;
  endtask

  task automatic randomData();
    for (int k = 0; k < N_REQ; k++) begin
      if ($urandom_range(0, 2) == 0) setData(k, 32'($urandom_range(0, 999)));
      else setData(k, $urandom);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rsp_valid"}, 80'(rsp_valid_o), 80'(0));
    checkOutput({tag, "_req_ready"}, 80'(req_ready_o), 80'(0));
    checkOutput({tag, "_conv_start"}, 80'(conv_start_o), 80'(0));
    checkOutput({tag, "_conv_dat"}, 80'(conv_dat_o), 80'(0));
    checkOutput({tag, "_rsp_id"}, 80'(rsp_id_o), 80'(0));
    checkOutput({tag, "_rsp_ascii"}, rsp_ascii_o, 80'(0));
    checkOutput({tag, "_rsp_width"}, 80'(rsp_width_o), 80'(0));
    checkOutput({tag, "_rsp_err"}, 80'(rsp_err_o), 80'(0));
    checkOutput({tag, "_conv_rst"}, 80'(conv_rst_o), 80'(0));
  endtask

  task automatic doReset();
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    rst_i       = 1'b1;
    settle();
    checkOutput("conv_rst_in_reset", 80'(conv_rst_o), 80'(1));
    tick();
    tick();
    rst_i   = 1'b0;
    ref_ptr = N_REQ - 1;
    settle();
    checkIdleOutputs("reset");
  endtask

  // One request/response transaction started in an IDLE cycle; gap_at drops ce_i for 3 cycles.
  task automatic applyStimulus(input logic [N_REQ-1:0] mask, input int stall, input int gap_at);
    int          win;
    int          t0;
    int          exp_lat;
    logic [31:0] wdata;
    logic [79:0] ea;
    logic [3:0]  ew;
    win         = pickRef(mask, ref_ptr);
    wdata       = req_data_i[win*32 +: 32];
    exp_lat     = (gap_at > 0) ? 2 + CONV_LAT + 3 : 2 + CONV_LAT;
    req_valid_i = mask;
    settle();
    t0 = cyc;
    checkOutput("ready_grant", 80'(req_ready_o), 80'(1) << win);
    tick();
    checkOutput("start_pulse", 80'(conv_start_o), 80'(1));
    checkOutput("conv_dat", 80'(conv_dat_o), 80'(wdata));
    checkOutput("ready_busy", 80'(req_ready_o), 80'(0));
    tick();
    checkOutput("start_once", 80'(conv_start_o), 80'(0));
    while (!rsp_valid_o && (cyc - t0) < MAX_WAIT) begin
      tick();
      if (gap_at > 0) begin
        if ((cyc - t0) == gap_at) ce_i = 1'b0;
        else if ((cyc - t0) == gap_at + 3) ce_i = 1'b1;
      end
    end
    ce_i = 1'b1;
    checkOutput("rsp_latency", 80'(cyc - t0), 80'(exp_lat));
    decAscii(wdata, ea, ew);
    for (int s = 0; s <= stall; s++) begin
      checkOutput("rsp_valid", 80'(rsp_valid_o), 80'(1));
      checkOutput("rsp_id", 80'(rsp_id_o), 80'(win));
      checkOutput("rsp_ascii", rsp_ascii_o, ea);
      checkOutput("rsp_width", 80'(rsp_width_o), 80'(ew));
      checkOutput("rsp_err", 80'(rsp_err_o), 80'(0));
      checkOutput("ready_in_resp", 80'(req_ready_o), 80'(0));
      if (s == stall) rsp_ready_i = 1'b1;
      tick();
    end
    rsp_ready_i = 1'b0;
    ref_ptr     = win;
    settle();
    checkOutput("rsp_dropped", 80'(rsp_valid_o), 80'(0));
  endtask

  initial begin
    rst_i       = 1'b1;
    ce_i        = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    rsp_ready_i = 1'b0;
    extra_done  = 1'b0;
    model_mute  = 1'b0;
    ref_ptr     = N_REQ - 1;

    doReset();

    $display("[TB] single request, operand 1234");
    setData(0, 32'd1234);
    applyStimulus(4'b0001, 0, 0);
    checkOutput("ascii_1234", rsp_ascii_o, 80'h31323334);
    checkOutput("width_1234", 80'(rsp_width_o), 80'(4));
    req_valid_i = '0;

    $display("[TB] all requesters valid, fairness rotation");
    doReset();
    randomData();
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 0, 0);

    $display("[TB] response back-pressure");
    randomData();
    applyStimulus(4'b1010, 5, 0);
    applyStimulus(4'b1010, 0, 0);

    $display("[TB] clock enable gap during WAIT");
    randomData();
    applyStimulus(4'b0110, 0, 5);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 20; i++) begin
      randomData();
      applyStimulus(N_REQ'($urandom_range(1, 15)), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? 5 : 0);
    end
    req_valid_i = '0;
    tick();

    $display("[TB] reset during WAIT");
    setData(2, 32'd987654);
    req_valid_i = 4'b0100;
    settle();
    tick();
    req_valid_i = '0;
    repeat (4) tick();
    rst_i = 1'b1;
    settle();
    checkOutput("conv_rst_mid_wait", 80'(conv_rst_o), 80'(1));
    tick();
    rst_i   = 1'b0;
    ref_ptr = N_REQ - 1;
    settle();
    checkIdleOutputs("midwait");
    repeat (4) tick();
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("late_done_ignored", 80'(rsp_valid_o), 80'(0));
      tick();
    end
    randomData();
    applyStimulus(4'b0101, 0, 0);
    req_valid_i = '0;

`ifdef BCD_CONV_SCHED_TIMEOUT_EN
    begin
      int t0;
      $display("[TB] converter timeout");
      model_mute = 1'b1;
      setData(1, 32'd42);
      req_valid_i = 4'b0010;
      settle();
      t0 = cyc;
      tick();
      req_valid_i = '0;
      while (!rsp_valid_o && (cyc - t0) < MAX_WAIT) tick();
      checkOutput("tmo_latency", 80'(cyc - t0), 80'(66));
      checkOutput("tmo_conv_rst", 80'(conv_rst_o), 80'(1));
      checkOutput("tmo_err", 80'(rsp_err_o), 80'(1));
      checkOutput("tmo_ascii", rsp_ascii_o, 80'(0));
      checkOutput("tmo_width", 80'(rsp_width_o), 80'(0));
      checkOutput("tmo_id", 80'(rsp_id_o), 80'(1));
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      settle();
      checkOutput("tmo_conv_rst_end", 80'(conv_rst_o), 80'(0));
      checkOutput("tmo_rsp_dropped", 80'(rsp_valid_o), 80'(0));
      model_mute = 1'b0;
    end
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
